// File: rtl/register_bank_reader.sv
// Read-side sequencer: bursts count words from a synchronous register bank onto valid/ready.
// Optional macro READBACK_PARITY_EN adds a registered out_parity output (^out_data).
module register_bank_reader #(
    parameter int unsigned N      = 24,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [N-1:0]      rd_data,
    output logic [N-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef READBACK_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam int unsigned CntW = ADDR_W + 1;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StHold, StFin} state_e;

    state_e            stateQ, stateD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [CntW-1:0]   remQ, remD;
    logic [2:0]        waitQ, waitD;
    logic [N-1:0]      dataQ, dataD;
    logic              parityQ, parityD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ  <= StIdle;
            addrQ   <= '0;
            remQ    <= '0;
            waitQ   <= '0;
            dataQ   <= '0;
            parityQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            addrQ   <= addrD;
            remQ    <= remD;
            waitQ   <= waitD;
            dataQ   <= dataD;
            parityQ <= parityD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        addrD   = addrQ;
        remD    = remQ;
        waitD   = waitQ;
        dataD   = dataQ;
        parityD = parityQ;
        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    if (count == '0) begin
                        stateD = StFin;
                    end else begin
                        addrD  = base_addr;
                        remD   = (count > CntW'(DEPTH)) ? CntW'(DEPTH) : count;
                        stateD = StIssue;
                    end
                end
            end
            StIssue: begin
                waitD  = 3'(RD_LAT - 1);
                stateD = StWait;
            end
            StWait: begin
                // Last wait cycle is the one in which the bank presents the word.
                if (waitQ == '0) begin
                    dataD   = rd_data;
                    parityD = ^rd_data;
                    stateD  = StHold;
                end else begin
                    waitD = waitQ - 3'd1;
                end
            end
            StHold: begin
                if (out_ready) begin
                    remD   = remQ - CntW'(1);
                    addrD  = addrQ + ADDR_W'(1);
                    stateD = (remQ == CntW'(1)) ? StFin : StIssue;
                end
            end
            StFin: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_comb begin
        rd_en     = (stateQ == StIssue);
        rd_addr   = (stateQ == StIssue) ? addrQ : '0;
        out_data  = dataQ;
        out_valid = (stateQ == StHold);
        out_last  = (stateQ == StHold) && (remQ == CntW'(1));
        busy      = (stateQ != StIdle);
        done      = (stateQ == StFin);
    end

`ifdef READBACK_PARITY_EN
    assign out_parity = parityQ;
`else
    logic unusedParity;
    assign unusedParity = parityQ;
`endif

endmodule
